// File: rtl/output_capture_if.sv
// Result-port and FIFO read-side signal bundle for output_capture.
// master: the side driving the result port and draining the FIFO.
// slave:  the output_capture receiver itself.
interface output_capture_if #(
    parameter int unsigned DEPTH = 16
) ();
    logic [15:0]            data_in;
    logic                   data_ready;
    logic                   rd_en;
    logic [15:0]            rd_data;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    modport master (
        output data_in, data_ready, rd_en,
        input  rd_data, fifo_empty, fifo_full, fifo_count
    );

    modport slave (
        input  data_in, data_ready, rd_en,
        output rd_data, fifo_empty, fifo_full, fifo_count
    );
endinterface

// File: rtl/output_capture.sv
// output_capture: host-side receiver for the 16-bit result port.
// Detects rising edges of data_ready, decodes load/done marker words into
// sticky status flags, and buffers result words in a first-word-fall-through
// FIFO that downstream logic drains via rd_en.
// Optional feature macro: OUTPUT_CAPTURE_CHECKSUM_EN adds a rotate-xor
// checksum over every result word seen during a run.
module output_capture #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [15:0] LOAD_MARKER = 16'h9999,
    parameter logic [15:0] DONE_MARKER = 16'hF0F0
) (
    input  logic                 clk,
    input  logic                 reset,
    output_capture_if.slave      bus,
    output logic                 load_seen,
    output logic                 run_done,
    output logic                 overflow,
    output logic [15:0]          result_count
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            ready_q;
    logic            ev;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;
    logic            wr;
    logic            drop;
    logic            set_load;
    logic            set_done;
    logic            new_run;

    assign ev   = bus.data_ready & ~ready_q;
    assign full = (count == CW'(DEPTH));
    assign pop  = bus.rd_en & (count != '0);
    // A full FIFO still accepts the word when the head leaves in the same cycle.
    assign wr   = push & (~full | pop);
    assign drop = push & full & ~pop;

    assign bus.rd_data    = mem[rd_ptr];
    assign bus.fifo_empty = (count == '0);
    assign bus.fifo_full  = full;
    assign bus.fifo_count = count;

    // Ready edge detector and FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            state   <= IDLE;
        end else begin
            ready_q <= bus.data_ready;
            state   <= state_next;
        end
    end

    // Marker decode: next state and per-event actions
    always_comb begin
        state_next = state;
        push       = 1'b0;
        set_load   = 1'b0;
        set_done   = 1'b0;
        new_run    = 1'b0;
        case (state)
            IDLE: begin
                if (ev && bus.data_in == LOAD_MARKER) begin
                    set_load   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ev) begin
                    if (bus.data_in == DONE_MARKER) begin
                        set_done   = 1'b1;
                        state_next = DONE;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ev && bus.data_in == LOAD_MARKER) begin
                    new_run    = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= bus.data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr) - CW'(pop);
        end
    end

    // Sticky status flags and saturating result counter
    always_ff @(posedge clk) begin
        if (reset) begin
            load_seen    <= 1'b0;
            run_done     <= 1'b0;
            overflow     <= 1'b0;
            result_count <= '0;
        end else begin
            if (set_load) begin
                load_seen <= 1'b1;
            end
            if (set_done) begin
                run_done <= 1'b1;
            end else if (new_run) begin
                run_done <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (new_run) begin
                result_count <= '0;
            end else if (push && result_count != 16'hFFFF) begin
                result_count <= result_count + 16'd1;
            end
        end
    end

`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
    // Rotate-left-xor checksum over every result seen, including dropped ones
    always_ff @(posedge clk) begin
        if (reset || new_run) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= {checksum[14:0], checksum[15]} ^ bus.data_in;
        end
    end
`endif

endmodule

// File: tb/tb_output_capture.sv
// Self-checking bench for output_capture: directed scenarios plus a
// randomized event/pop mix compared against a queue-based reference model.
module tb_output_capture;

    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] LOADM = 16'h9999;
    localparam logic [15:0] DONEM = 16'hF0F0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_seen;
    logic        run_done;
    logic        overflow;
    logic [15:0] result_count;
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model: FIFO contents as a queue, run phase from the flags.
    logic [15:0] q[$];
    bit          m_load, m_done, m_ovf, m_prev;
    int          m_rc;
    logic [15:0] m_csum;

    output_capture_if #(.DEPTH(DEPTH)) bus ();

    output_capture #(
        .DEPTH(DEPTH),
        .LOAD_MARKER(LOADM),
        .DONE_MARKER(DONEM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .load_seen(load_seen),
        .run_done(run_done),
        .overflow(overflow),
        .result_count(result_count)
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_load = 0; m_done = 0; m_ovf = 0; m_prev = 0; m_rc = 0; m_csum = '0;
    endtask

    // Apply one edge's worth of port activity to the model.
    task automatic model_step(input bit lvl, input logic [15:0] w, input bit rd);
        bit e;
        bit popped;
        int sz;
        e = lvl & ~m_prev;
        m_prev = lvl;
        sz = q.size();
        popped = rd && sz > 0;
        if (popped) void'(q.pop_front());
        if (e) begin
            if (!m_load) begin
                if (w == LOADM) m_load = 1;
            end else if (!m_done) begin
                if (w == DONEM) begin
                    m_done = 1;
                end else begin
                    if (m_rc < 65535) m_rc++;
                    m_csum = {m_csum[14:0], m_csum[15]} ^ w;
                    if (sz < int'(DEPTH) || popped) q.push_back(w);
                    else m_ovf = 1;
                end
            end else if (w == LOADM) begin
                m_done = 0; m_rc = 0; m_csum = '0;
            end
        end
    endtask

    // Drive one clock cycle of inputs; outputs are stable 1 time unit after the edge.
    task automatic cycle(input bit lvl, input logic [15:0] w, input bit rd);
        bus.data_ready = lvl;
        bus.data_in    = w;
        bus.rd_en      = rd;
        @(posedge clk);
        model_step(lvl, w, rd);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        cycle(1'b1, w, 1'b0);
        cycle(1'b0, w, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.data_ready = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.fifo_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.fifo_empty); else passed++;
        total++; if (bus.fifo_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); else passed++;
        total++; if (bus.fifo_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.fifo_full); else passed++;
        total++; if (bus.rd_data !== 16'h0000) $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); else passed++;
        total++; if ({load_seen, run_done, overflow} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {load_seen, run_done, overflow}); else passed++;
        total++; if (result_count !== 16'd0) $display("FAIL reset_result_count got=%0d exp=0", result_count); else passed++;
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
        total++; if (checksum !== 16'd0) $display("FAIL reset_checksum got=%h exp=0000", checksum); else passed++;
`endif
    endtask

    task automatic test_basic_run();
        do_reset();
        send(16'h9999); send(16'h0012); send(16'h0034); send(16'hF0F0);
        total++; if (load_seen !== 1'b1) $display("FAIL basic_load_seen got=%b exp=1", load_seen); else passed++;
        total++; if (run_done !== 1'b1) $display("FAIL basic_run_done got=%b exp=1", run_done); else passed++;
        total++; if (result_count !== 16'd2) $display("FAIL basic_result_count got=%0d exp=2", result_count); else passed++;
        total++; if (bus.rd_data !== 16'h0012) $display("FAIL basic_pop0 got=%h exp=0012", bus.rd_data); else passed++;
        cycle(1'b0, '0, 1'b1);
        total++; if (bus.rd_data !== 16'h0034) $display("FAIL basic_pop1 got=%h exp=0034", bus.rd_data); else passed++;
        cycle(1'b0, '0, 1'b1);
        total++; if (bus.fifo_empty !== 1'b1) $display("FAIL basic_empty_after got=%b exp=1", bus.fifo_empty); else passed++;
        // A pop on an empty FIFO must not disturb anything.
        cycle(1'b0, '0, 1'b1);
        total++; if (bus.fifo_count !== 5'd0 || overflow !== 1'b0) $display("FAIL basic_empty_pop count=%0d ovf=%b exp=0/0", bus.fifo_count, overflow); else passed++;
    endtask

    task automatic test_held_ready();
        do_reset();
        send(16'h1234);
        total++; if (bus.fifo_count !== 5'd0 || load_seen !== 1'b0) $display("FAIL held_idle_discard count=%0d load=%b exp=0/0", bus.fifo_count, load_seen); else passed++;
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h9999, 1'b0);
        cycle(1'b0, 16'h9999, 1'b0);
        total++; if (load_seen !== 1'b1) $display("FAIL held_load got=%b exp=1", load_seen); else passed++;
        total++; if (bus.fifo_count !== 5'd0 || result_count !== 16'd0) $display("FAIL held_single_event count=%0d rc=%0d exp=0/0", bus.fifo_count, result_count); else passed++;
        send(16'h0042);
        total++; if (bus.rd_data !== 16'h0042 || result_count !== 16'd1) $display("FAIL held_in_run rd=%h rc=%0d exp=0042/1", bus.rd_data, result_count); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        send(LOADM);
        for (int i = 1; i <= 17; i++) send(16'(i));
        total++; if (bus.fifo_full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", bus.fifo_full); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else passed++;
        total++; if (result_count !== 16'd17) $display("FAIL ovf_result_count got=%0d exp=17", result_count); else passed++;
        total++; if (bus.fifo_count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", bus.fifo_count); else passed++;
        for (int i = 1; i <= 16; i++) begin
            total++; if (bus.rd_data !== 16'(i)) $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.rd_data, 16'(i)); else passed++;
            cycle(1'b0, '0, 1'b1);
        end
        total++; if (bus.fifo_empty !== 1'b1) $display("FAIL ovf_drained got=%b exp=1", bus.fifo_empty); else passed++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        send(LOADM);
        for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i));
        cycle(1'b1, 16'h00AA, 1'b1);
        cycle(1'b0, 16'h00AA, 1'b0);
        total++; if (bus.fifo_count !== 5'd16) $display("FAIL fpp_count got=%0d exp=16", bus.fifo_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fpp_overflow got=%b exp=0", overflow); else passed++;
        total++; if (bus.rd_data !== 16'h0101) $display("FAIL fpp_head got=%h exp=0101", bus.rd_data); else passed++;
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
        total++; if (bus.rd_data !== 16'h00AA || bus.fifo_count !== 5'd1) $display("FAIL fpp_last rd=%h count=%0d exp=00AA/1", bus.rd_data, bus.fifo_count); else passed++;
        // Push and pop together on an empty FIFO: push wins, pop is ignored.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 16'h0777, 1'b1);
        total++; if (bus.fifo_count !== 5'd1 || bus.rd_data !== 16'h0777) $display("FAIL fpp_empty_both count=%0d rd=%h exp=1/0777", bus.fifo_count, bus.rd_data); else passed++;
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        send(LOADM);
        send(16'h0005);
        do_reset();
        total++; if (bus.fifo_empty !== 1'b1 || bus.fifo_count !== 5'd0) $display("FAIL mid_reset_fifo empty=%b count=%0d exp=1/0", bus.fifo_empty, bus.fifo_count); else passed++;
        total++; if ({load_seen, run_done, overflow} !== 3'b000 || result_count !== 16'd0) $display("FAIL mid_reset_flags flags=%b rc=%0d exp=000/0", {load_seen, run_done, overflow}, result_count); else passed++;
        total++; if (bus.rd_data !== 16'h0000) $display("FAIL mid_reset_rd_data got=%h exp=0000", bus.rd_data); else passed++;
        send(16'h0007);
        total++; if (bus.fifo_count !== 5'd0 || result_count !== 16'd0) $display("FAIL mid_reset_discard count=%0d rc=%0d exp=0/0", bus.fifo_count, result_count); else passed++;
    endtask

`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send(LOADM); send(16'h0001); send(16'h0002);
        total++; if (checksum !== 16'h0000) $display("FAIL csum_a got=%h exp=0000", checksum); else passed++;
        send(DONEM); send(LOADM);
        total++; if (checksum !== 16'h0000 || result_count !== 16'd0) $display("FAIL csum_new_run cs=%h rc=%0d exp=0000/0", checksum, result_count); else passed++;
        send(16'h0001); send(16'h0001);
        total++; if (checksum !== 16'h0003) $display("FAIL csum_b got=%h exp=0003", checksum); else passed++;
    endtask
`endif

    task automatic test_random();
        bit          lvl;
        bit          rd;
        logic [15:0] w;
        int          r;
        do_reset();
        send(LOADM);
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 39);
            if (r == 0) w = DONEM;
            else if (r == 1) w = LOADM;
            else w = 16'($urandom);
            lvl = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < 2; s++) begin
                rd = ($urandom_range(0, 2) == 0);
                cycle(s == 0 ? lvl : 1'b0, w, rd);
                total++; if (bus.fifo_count !== 5'(q.size())) $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, bus.fifo_count, q.size()); else passed++;
                total++; if (bus.fifo_full !== (q.size() == int'(DEPTH))) $display("FAIL rnd_full it=%0d got=%b", it, bus.fifo_full); else passed++;
                if (q.size() > 0) begin
                    total++; if (bus.rd_data !== q[0]) $display("FAIL rnd_head it=%0d got=%h exp=%h", it, bus.rd_data, q[0]); else passed++;
                end else begin
                    total++; if (bus.fifo_empty !== 1'b1) $display("FAIL rnd_empty it=%0d got=%b exp=1", it, bus.fifo_empty); else passed++;
                end
                total++; if ({load_seen, run_done, overflow} !== {m_load, m_done, m_ovf}) $display("FAIL rnd_flags it=%0d got=%b exp=%b", it, {load_seen, run_done, overflow}, {m_load, m_done, m_ovf}); else passed++;
                total++; if (result_count !== 16'(m_rc)) $display("FAIL rnd_result_count it=%0d got=%0d exp=%0d", it, result_count, m_rc); else passed++;
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
                total++; if (checksum !== m_csum) $display("FAIL rnd_checksum it=%0d got=%h exp=%h", it, checksum, m_csum); else passed++;
`endif
            end
        end
    endtask

    initial begin
        bus.data_in = '0;
        bus.data_ready = 1'b0;
        bus.rd_en = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_held_ready();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_run();
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
